// File: rtl/sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the flagged synchronous FIFO:
//   fifo_flags_t   - bundle of the four count-derived status flags
//   FLAGS_RESET    - flag values for an empty FIFO
//   fifo_addr_w    - address width for a given depth
//   fifo_count_w   - occupancy counter width (must be able to hold DEPTH)
//   fifo_cfg_ok    - parameter legality check used at elaboration
//   fifo_flags     - flag values for a given occupancy
// ----------------------------------------------------------------------------
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almostFull;
        logic almostEmpty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, almostFull: 1'b0, almostEmpty: 1'b1};

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the counter can represent DEPTH itself.
    function automatic int fifo_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_cfg_ok(input int width, input int depth, input int af, input int ae);
        return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

    function automatic fifo_flags_t fifo_flags(input int count, input int depth, input int af, input int ae);
        fifo_flags_t f;
        f.full        = (count == depth);
        f.empty       = (count == 0);
        f.almostFull  = (count >= af);
        f.almostEmpty = (count <= ae);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
// Storage array for sync_fifo_flags: one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (combinational from i_raddr)
// ----------------------------------------------------------------------------
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port; the array has no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read lets FWFT show the head word without a cycle of delay.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// sync_fifo_flags
// Single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous flush and an
// optional first-word-fall-through read mode.
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   flush        - synchronous empty-and-clear (ignores w_en/r_en that cycle)
//   w_en/data_in - write request and data
//   r_en         - read request (FWFT=1: acknowledge the displayed word)
//   data_out     - read data
//   full/empty/almost_full/almost_empty - registered occupancy flags
//   count        - current occupancy 0..DEPTH
//   overflow/underflow - sticky rejected-write / rejected-read flags
// ----------------------------------------------------------------------------
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   w_en,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   r_en,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = fifo_count_w(DEPTH);

    if (!fifo_cfg_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
        $error("sync_fifo_flags: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    fifo_flags_t      r_flags;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_rdAcc;
    logic             w_wrAcc;
    logic             w_memWe;
    logic [CNT_W-1:0] w_countNext;
    fifo_flags_t      w_flagsNext;
    logic [WIDTH-1:0] w_memRdata;

    // A read is only ever accepted from a non-empty FIFO; a write into a full
    // FIFO is accepted only when a read frees the slot in the same cycle.
    assign w_rdAcc     = r_en && !r_flags.empty;
    assign w_wrAcc     = w_en && (!r_flags.full || w_rdAcc);
    assign w_countNext = r_count + CNT_W'(w_wrAcc) - CNT_W'(w_rdAcc);
    assign w_memWe     = w_wrAcc && !rst && !flush;

    // Flags are computed from the next count so they line up with count.
    always_comb begin
        w_flagsNext = fifo_flags(int'(w_countNext), DEPTH, AF_LEVEL, AE_LEVEL);
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_memWe),
        .i_waddr (r_wrPtr[ADDR_W-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rdPtr[ADDR_W-1:0]),
        .o_rdata (w_memRdata)
    );

    // Pointer, count and flag state. Reset and flush both return everything
    // to the empty state and drop any request presented in that cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_flags     <= FLAGS_RESET;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= w_countNext;
            r_flags <= w_flagsNext;
            if (w_en && !w_wrAcc) begin
                r_overflow <= 1'b1;
            end
            if (r_en && !w_rdAcc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; blanked to zero while empty.
        assign data_out = r_flags.empty ? '0 : w_memRdata;
    end else begin : g_std
        logic [WIDTH-1:0] r_dataOut;

        // Registered read: the head word is captured on an accepted read and
        // held until the next one.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_dataOut <= '0;
            end else if (w_rdAcc) begin
                r_dataOut <= w_memRdata;
            end
        end

        assign data_out = r_dataOut;
    end

    assign full         = r_flags.full;
    assign empty        = r_flags.empty;
    assign almost_full  = r_flags.almostFull;
    assign almost_empty = r_flags.almostEmpty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Drives one registered-read FIFO (dut0) and one FWFT FIFO (dut1) with the
// same stimulus. A queue holds the words the FIFO should contain; accepted
// writes push, accepted reads pop the word dut0 must present next.
// ----------------------------------------------------------------------------
module tb_sync_fifo_flags;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst, flush, w_en, r_en;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic [3:0] count0, count1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [5:0] stat0, stat1;

    assign stat0 = {full0, empty0, af0, ae0, ovf0, unf0};
    assign stat1 = {full1, empty1, af1, ae1, ovf1, unf1};

    int vectors = 0;
    int errors  = 0;

    logic [7:0] modelQ[$];
    logic [7:0] mRd0;
    bit         mOvf, mUnf;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    // Expected {full, empty, almost_full, almost_empty, overflow, underflow}.
    function automatic logic [5:0] expStat();
        int n;
        n = modelQ.size();
        return {n == D, n == 0, n >= 6, n <= 1, mOvf, mUnf};
    endfunction

    function automatic logic [7:0] expFwft();
        return (modelQ.size() > 0) ? modelQ[0] : 8'h00;
    endfunction

    // One clock of stimulus; the model is updated at the edge and the task
    // returns 1 time unit after it, where outputs are sampled.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic f);
        bit rdAcc, wrAcc;
        @(negedge clk);
        w_en = w; data_in = d; r_en = r; flush = f;
        @(posedge clk);
        if (f) begin
            modelQ.delete(); mOvf = 1'b0; mUnf = 1'b0; mRd0 = 8'h00;
        end else begin
            rdAcc = r && (modelQ.size() > 0);
            wrAcc = w && ((modelQ.size() < D) || rdAcc);
            if (rdAcc) mRd0 = modelQ.pop_front();
            if (wrAcc) modelQ.push_back(d);
            if (w && !wrAcc) mOvf = 1'b1;
            if (r && !rdAcc) mUnf = 1'b1;
        end
        #1;
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
    endtask

    task automatic doReset(input logic w, input logic r);
        @(negedge clk);
        rst = 1'b1; w_en = w; r_en = r; data_in = 8'hEE;
        @(posedge clk);
        modelQ.delete(); mOvf = 1'b0; mUnf = 1'b0; mRd0 = 8'h00;
        #1;
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic test_reset();
        doReset(1'b1, 1'b1);
        vectors++;
        if ({count0, stat0, dout0} !== {4'd0, 6'b010100, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_dut0: got count=%0d stat=%b dout=%h, expected count=0 stat=010100 dout=00", count0, stat0, dout0);
        end
        vectors++;
        if ({count1, stat1, dout1} !== {4'd0, 6'b010100, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got count=%0d stat=%b dout=%h, expected count=0 stat=010100 dout=00", count1, stat1, dout1);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] v;
        for (int i = 0; i < D; i++) begin
            v = 8'(8'h11 * (i + 1));
            applyStimulus(1'b1, v, 1'b0, 1'b0);
            vectors++;
            if ({count0, stat0} !== {4'(i + 1), expStat()}) begin
                errors++;
                $display("[TB] FAIL fill_%0d: got count=%0d stat=%b, expected count=%0d stat=%b", i, count0, stat0, i + 1, expStat());
            end
        end
        vectors++;
        if ({full0, af0, count0} !== {1'b1, 1'b1, 4'd8}) begin
            errors++;
            $display("[TB] FAIL fill_full: got full=%b af=%b count=%0d, expected 1 1 8", full0, af0, count0);
        end
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
        vectors++;
        if ({ovf0, count0, ovf1} !== {1'b1, 4'd8, 1'b1}) begin
            errors++;
            $display("[TB] FAIL overflow: got ovf0=%b count=%0d ovf1=%b, expected 1 8 1", ovf0, count0, ovf1);
        end
        for (int i = 0; i < D; i++) begin
            v = 8'(8'h11 * (i + 1));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if ({dout0, dout1} !== {v, expFwft()} || mRd0 !== v) begin
                errors++;
                $display("[TB] FAIL drain_%0d: got dout0=%h dout1=%h, expected %h %h", i, dout0, dout1, v, expFwft());
            end
        end
        vectors++;
        if ({empty0, empty1, unf0} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL drain_empty: got empty0=%b empty1=%b unf=%b, expected 1 1 0", empty0, empty1, unf0);
        end
    endtask

    task automatic test_underflow_fwft();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        vectors++;
        if ({unf0, count0, stat0} !== {1'b1, 4'd1, expStat()}) begin
            errors++;
            $display("[TB] FAIL rw_empty: got unf=%b count=%0d stat=%b, expected 1 1 %b", unf0, count0, stat0, expStat());
        end
        vectors++;
        if ({dout1, empty1, dout0} !== {8'hA5, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL fwft_show: got dout1=%h empty1=%b dout0=%h, expected a5 0 00", dout1, empty1, dout0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if ({dout0, dout1, empty0} !== {8'hA5, 8'h00, 1'b1}) begin
            errors++;
            $display("[TB] FAIL fwft_ack: got dout0=%h dout1=%h empty=%b, expected a5 00 1", dout0, dout1, empty0);
        end
    endtask

    task automatic test_full_rw();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            vectors++;
            if ({count0, ovf0, full0, dout0, dout1} !== {4'd8, 1'b0, 1'b1, 8'(8'h20 + i), expFwft()}) begin
                errors++;
                $display("[TB] FAIL full_rw_%0d: got count=%0d ovf=%b full=%b dout0=%h dout1=%h, expected 8 0 1 %h %h",
                         i, count0, ovf0, full0, dout0, dout1, 8'(8'h20 + i), expFwft());
            end
        end
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if ({dout0, dout1, count0} !== {mRd0, expFwft(), 4'(modelQ.size())}) begin
                errors++;
                $display("[TB] FAIL full_drain_%0d: got dout0=%h dout1=%h count=%0d, expected %h %h %0d",
                         i, dout0, dout1, count0, mRd0, expFwft(), modelQ.size());
            end
        end
        vectors++;
        if (dout0 !== 8'h43) begin
            errors++;
            $display("[TB] FAIL full_last: got %h, expected 43", dout0);
        end
    endtask

    task automatic test_thresholds();
        int n;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i < 7) begin
                applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
                n = i + 1;
            end else begin
                applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
                n = 13 - i;
            end
            vectors++;
            if ({af0, ae0, af1, ae1} !== {n >= 6, n <= 1, n >= 6, n <= 1}) begin
                errors++;
                $display("[TB] FAIL thresh_n%0d: got af=%b ae=%b (fwft af=%b ae=%b), expected af=%b ae=%b",
                         n, af0, ae0, af1, ae1, n >= 6, n <= 1);
            end
        end
    endtask

    task automatic test_flush();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (unf0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_pre_unf: got %b, expected 1", unf0);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
        vectors++;
        if ({count0, stat0, dout0, dout1} !== {4'd0, 6'b010100, 8'h00, 8'h00}) begin
            errors++;
            $display("[TB] FAIL flush: got count=%0d stat=%b dout0=%h dout1=%h, expected 0 010100 00 00", count0, stat0, dout0, dout1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1'b1, 8'(r * 16 + i + 1), 1'b0, 1'b0);
                vectors++;
                if ({full0, empty0, count0} !== {1'b0, 1'b0, 4'(i + 1)}) begin
                    errors++;
                    $display("[TB] FAIL wrap_w%0d_%0d: got full=%b empty=%b count=%0d, expected 0 0 %0d", r, i, full0, empty0, count0, i + 1);
                end
            end
            for (int i = 0; i < 6; i++) begin
                v = 8'(r * 16 + i + 1);
                applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
                vectors++;
                if ({dout0, dout1, empty0} !== {v, expFwft(), i == 5}) begin
                    errors++;
                    $display("[TB] FAIL wrap_r%0d_%0d: got dout0=%h dout1=%h empty=%b, expected %h %h %b",
                             r, i, dout0, dout1, empty0, v, expFwft(), i == 5);
                end
            end
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        doReset(1'b1, 1'b1);
        vectors++;
        if ({count0, stat0, dout0, count1, stat1, dout1} !== {4'd0, 6'b010100, 8'h00, 4'd0, 6'b010100, 8'h00}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got count0=%0d stat0=%b dout0=%h count1=%0d stat1=%b dout1=%h, expected 0 010100 00",
                     count0, stat0, dout0, count1, stat1, dout1);
        end
    endtask

    // Backstop so a stuck run still reports and terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        mRd0 = 8'h00; mOvf = 1'b0; mUnf = 1'b0;
        test_reset();
        test_fill_overflow();
        test_underflow_fwft();
        test_full_rw();
        test_thresholds();
        test_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
